vga_vtiming_gen: RTL and testbench

Parametrised vertical timing generator for the VGA output path. It advances one line per end-of-line strobe from the horizontal generator and decodes the line counter into back-porch, active, front-porch and sync regions. It drives vsync with configurable polarity, `vvideo_on`, `y_pos`/`y_pos_next`, frame start and end pulses, and a frame counter. An optional look-ahead request lets the convolution line buffers prefetch input rows before they are displayed.

---
 rtl/vga_timing_pkg.sv | 20 ++
 rtl/vga_vregion_decode.sv | 33 +++
 rtl/vga_vtiming_gen.sv | 179 +++++++++++++++++
 tb/tb_vga_vtiming_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA vertical timing types, 640x480 default constants and the frame-length helper.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        BACK   = 2'd0,
        ACTIVE = 2'd1,
        FRONT  = 2'd2,
        SYNC   = 2'd3
    } vregion_t;

    localparam int V_ACTIVE_640 = 480;
    localparam int V_FP_640     = 10;
    localparam int V_SYNC_640   = 2;
    localparam int V_BP_640     = 29;

    function automatic int v_total(input int bp, input int act, input int fp, input int sync);
        return bp + act + fp + sync;
    endfunction

endpackage

// File: rtl/vga_vregion_decode.sv
// Combinational decode of a line number into its vertical region and active-row index.
module vga_vregion_decode
    import vga_timing_pkg::*;
#(
    parameter int V_BP     = V_BP_640,
    parameter int V_ACTIVE = V_ACTIVE_640,
    parameter int V_FP     = V_FP_640,
    parameter int LW       = 10
) (
    input  logic [LW-1:0] line_i,
    output vregion_t      region_o,
    output logic [LW-1:0] row_o
);

    localparam logic [LW-1:0] ACT_START  = LW'(V_BP);
    localparam logic [LW-1:0] ACT_END    = LW'(V_BP + V_ACTIVE);
    localparam logic [LW-1:0] SYNC_START = LW'(V_BP + V_ACTIVE + V_FP);

    // Zero-length porches fall out naturally: an empty range never matches.
    always_comb begin
        region_o = SYNC;
        row_o    = '0;
        if (line_i < ACT_START) begin
            region_o = BACK;
        end else if (line_i < ACT_END) begin
            region_o = ACTIVE;
            row_o    = line_i - ACT_START;
        end else if (line_i < SYNC_START) begin
            region_o = FRONT;
        end
    end

endmodule

// File: rtl/vga_vtiming_gen.sv
// Vertical timing generator: one line per qualified end-of-line strobe.
// Optional row prefetch look-ahead is built when VGA_VTIMING_PREFETCH_EN is defined.
//
// state  | meaning
// BACK   | back-porch lines before the visible area
// ACTIVE | visible lines, y_pos valid
// FRONT  | front-porch lines after the visible area
// SYNC   | vsync asserted, last lines of the frame
module vga_vtiming_gen
    import vga_timing_pkg::*;
#(
    parameter int V_ACTIVE  = V_ACTIVE_640,
    parameter int V_FP      = V_FP_640,
    parameter int V_SYNC    = V_SYNC_640,
    parameter int V_BP      = V_BP_640,
    parameter int SYNC_POL  = 0,
    parameter int LOOKAHEAD = 2,
    parameter int FRAME_W   = 8,
    localparam int V_TOTAL  = v_total(V_BP, V_ACTIVE, V_FP, V_SYNC),
    localparam int LW       = $clog2(V_TOTAL)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pixel_tick,
    input  logic               eol,
    output logic               vsync,
    output logic               vvideo_on,
    output logic [LW-1:0]      y_pos,
    output logic [LW-1:0]      y_pos_next,
    output logic               sof,
    output logic               eof,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               prefetch,
    output logic [LW-1:0]      prefetch_y
);

    localparam logic [LW-1:0] LAST_LINE = LW'(V_TOTAL - 1);
    localparam logic [LW-1:0] ACT_FIRST = LW'(V_BP);
    localparam logic [LW-1:0] ACT_LAST  = LW'(V_BP + V_ACTIVE - 1);
    localparam logic          SYNC_ON   = (SYNC_POL != 0);

    if (V_ACTIVE < 1 || V_SYNC < 1 || LOOKAHEAD < 1 || LOOKAHEAD >= V_TOTAL) begin : g_bad_param
        $error("vga_vtiming_gen: illegal vertical timing parameters");
    end

    logic               step;
    logic [LW-1:0]      line_q, line_d, line_inc;
    vregion_t           state_q, state_d, next_region;
    logic [LW-1:0]      next_row;
    logic               vsync_q, vsync_d;
    logic               vvideo_q, vvideo_d;
    logic [LW-1:0]      y_q, y_d;
    logic               sof_q, sof_d;
    logic               eof_q, eof_d;
    logic [FRAME_W-1:0] frame_q, frame_d;

    assign step     = pixel_tick & eol;
    assign line_inc = (line_q == LAST_LINE) ? '0 : line_q + LW'(1);

    vga_vregion_decode #(
        .V_BP     (V_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .LW       (LW)
    ) u_next_dec (
        .line_i   (line_inc),
        .region_o (next_region),
        .row_o    (next_row)
    );

    // Outputs decode the incoming line so they never lag line_q.
    always_comb begin
        line_d   = line_q;
        state_d  = state_q;
        vsync_d  = vsync_q;
        vvideo_d = vvideo_q;
        y_d      = y_q;
        sof_d    = 1'b0;
        eof_d    = 1'b0;
        frame_d  = frame_q;
        if (step) begin
            line_d   = line_inc;
            state_d  = next_region;
            vsync_d  = (next_region == SYNC) ? SYNC_ON : !SYNC_ON;
            vvideo_d = (next_region == ACTIVE);
            y_d      = next_row;
            sof_d    = (line_inc == ACT_FIRST);
            eof_d    = (line_q == ACT_LAST);
            if (line_q == LAST_LINE) begin
                frame_d = frame_q + FRAME_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            line_q   <= '0;
            state_q  <= BACK;
            vsync_q  <= !SYNC_ON;
            vvideo_q <= 1'b0;
            y_q      <= '0;
            sof_q    <= 1'b0;
            eof_q    <= 1'b0;
            frame_q  <= '0;
        end else begin
            line_q   <= line_d;
            state_q  <= state_d;
            vsync_q  <= vsync_d;
            vvideo_q <= vvideo_d;
            y_q      <= y_d;
            sof_q    <= sof_d;
            eof_q    <= eof_d;
            frame_q  <= frame_d;
        end
    end

    assign vsync      = vsync_q;
    assign vvideo_on  = vvideo_q;
    assign y_pos      = y_q;
    assign y_pos_next = next_row;
    assign sof        = sof_q;
    assign eof        = eof_q;
    assign frame_cnt  = frame_q;

`ifdef VGA_VTIMING_PREFETCH_EN
    logic [LW:0]   pf_sum;
    logic [LW-1:0] pf_line;
    vregion_t      pf_region;
    logic [LW-1:0] pf_row;
    logic          pf_q, pf_d;
    logic [LW-1:0] pf_y_q, pf_y_d;

    // Single compare-and-subtract suffices since LOOKAHEAD < V_TOTAL.
    always_comb begin
        pf_sum = {1'b0, line_inc} + (LW+1)'(LOOKAHEAD);
        if (pf_sum >= (LW+1)'(V_TOTAL)) begin
            pf_sum = pf_sum - (LW+1)'(V_TOTAL);
        end
        pf_line = pf_sum[LW-1:0];
    end

    vga_vregion_decode #(
        .V_BP     (V_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .LW       (LW)
    ) u_pf_dec (
        .line_i   (pf_line),
        .region_o (pf_region),
        .row_o    (pf_row)
    );

    always_comb begin
        pf_d   = pf_q;
        pf_y_d = pf_y_q;
        if (step) begin
            pf_d   = (pf_region == ACTIVE);
            pf_y_d = pf_row;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pf_q   <= 1'b0;
            pf_y_q <= '0;
        end else begin
            pf_q   <= pf_d;
            pf_y_q <= pf_y_d;
        end
    end

    assign prefetch   = pf_q;
    assign prefetch_y = pf_y_q;
`else
    assign prefetch   = 1'b0;
    assign prefetch_y = '0;
`endif

endmodule

// File: tb/tb_vga_vtiming_gen.sv
// Directed bench for vga_vtiming_gen: 640x480 defaults, look-ahead 40 and a tiny porch-less build.
module tb_vga_vtiming_gen;

`ifdef VGA_VTIMING_PREFETCH_EN
    localparam bit PF_EN = 1'b1;
`else
    localparam bit PF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pixel_tick = 1'b0;
    logic eol = 1'b0;

    always #5 clk = ~clk;

    // default 640x480, LOOKAHEAD=2
    logic       vs0, vv0, sof0, eof0, pf0;
    logic [9:0] y0, yn0, py0;
    logic [7:0] fc0;
    // LOOKAHEAD=40
    logic       vs2, vv2, sof2, eof2, pf2;
    logic [9:0] y2, yn2, py2;
    logic [7:0] fc2;
    // V_BP=0, V_ACTIVE=4, V_FP=0, V_SYNC=2, SYNC_POL=1, FRAME_W=2, LOOKAHEAD=1
    logic       vs1, vv1, sof1, eof1, pf1;
    logic [2:0] y1, yn1, py1;
    logic [1:0] fc1;

    vga_vtiming_gen dut0 (
        .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .eol(eol),
        .vsync(vs0), .vvideo_on(vv0), .y_pos(y0), .y_pos_next(yn0),
        .sof(sof0), .eof(eof0), .frame_cnt(fc0), .prefetch(pf0), .prefetch_y(py0)
    );

    vga_vtiming_gen #(.LOOKAHEAD(40)) dut2 (
        .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .eol(eol),
        .vsync(vs2), .vvideo_on(vv2), .y_pos(y2), .y_pos_next(yn2),
        .sof(sof2), .eof(eof2), .frame_cnt(fc2), .prefetch(pf2), .prefetch_y(py2)
    );

    vga_vtiming_gen #(
        .V_ACTIVE(4), .V_FP(0), .V_SYNC(2), .V_BP(0),
        .SYNC_POL(1), .LOOKAHEAD(1), .FRAME_W(2)
    ) dut1 (
        .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .eol(eol),
        .vsync(vs1), .vvideo_on(vv1), .y_pos(y1), .y_pos_next(yn1),
        .sof(sof1), .eof(eof1), .frame_cnt(fc1), .prefetch(pf1), .prefetch_y(py1)
    );

    int checks = 0;
    int failures = 0;
    int s = 0;
    int sof_seen = 0;
    int eof_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, s, obs, exp);
        end
    endtask

    task automatic do_step();
        @(negedge clk);
        pixel_tick = 1'b1;
        eol        = 1'b1;
        @(negedge clk);
        pixel_tick = 1'b0;
        eol        = 1'b0;
    endtask

    function automatic int row640(input int ln);
        return (ln >= 29 && ln <= 508) ? ln - 29 : 0;
    endfunction

    task automatic check_all();
        int ln, nx, t0, t2, l1, n1, t1;
        ln = s % 521;
        nx = (s + 1) % 521;
        t0 = (ln + 2) % 521;
        t2 = (ln + 40) % 521;
        chk("vvideo0", vv0, (ln >= 29 && ln <= 508));
        chk("y0", y0, row640(ln));
        chk("ynext0", yn0, row640(nx));
        chk("vsync0", vs0, (ln < 519));
        chk("sof0", sof0, (ln == 29));
        chk("eof0", eof0, (ln == 509));
        chk("frame0", fc0, (s / 521) % 256);
        chk("pf0", pf0, PF_EN && (t0 >= 29 && t0 <= 508));
        chk("pfy0", py0, PF_EN ? row640(t0) : 0);
        chk("pf2", pf2, PF_EN && (t2 >= 29 && t2 <= 508));
        chk("pfy2", py2, PF_EN ? row640(t2) : 0);
        l1 = s % 6;
        n1 = (s + 1) % 6;
        t1 = (l1 + 1) % 6;
        chk("vvideo1", vv1, (l1 < 4));
        chk("y1", y1, (l1 < 4) ? l1 : 0);
        chk("ynext1", yn1, (n1 < 4) ? n1 : 0);
        chk("vsync1", vs1, (l1 >= 4));
        chk("sof1", sof1, (l1 == 0));
        chk("eof1", eof1, (l1 == 4));
        chk("frame1", fc1, (s / 6) % 4);
        chk("pf1", pf1, PF_EN && (t1 < 4));
        chk("pfy1", py1, (PF_EN && t1 < 4) ? t1 : 0);
    endtask

    initial begin
        // Reset with a coincident step: the step must be ignored.
        reset = 1'b1;
        pixel_tick = 1'b1;
        eol = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        pixel_tick = 1'b0;
        eol = 1'b0;
        @(negedge clk);
        chk("rst_vsync0", vs0, 1);
        chk("rst_vvideo0", vv0, 0);
        chk("rst_y0", y0, 0);
        chk("rst_sof0", sof0, 0);
        chk("rst_eof0", eof0, 0);
        chk("rst_frame0", fc0, 0);
        chk("rst_pf0", pf0, 0);
        chk("rst_pfy0", py0, 0);
        chk("rst_vsync1", vs1, 0);
        chk("rst_vvideo1", vv1, 0);
        chk("rst_frame1", fc1, 0);

        // One complete frame plus the wrap step.
        for (int k = 1; k <= 521; k++) begin
            do_step();
            s++;
            check_all();
            if (s <= 520) begin
                sof_seen += int'(sof0);
                eof_seen += int'(eof0);
            end
            if (s == 29) begin
                @(negedge clk);
                chk("sof0_one_clk", sof0, 0);
                chk("y0_hold_idle", y0, 0);
            end
            if (s == 509) begin
                @(negedge clk);
                chk("eof0_one_clk", eof0, 0);
            end
            if (s == 100) begin
                @(negedge clk);
                eol = 1'b1;
                @(negedge clk);
                @(negedge clk);
                @(negedge clk);
                eol = 1'b0;
                pixel_tick = 1'b1;
                @(negedge clk);
                pixel_tick = 1'b0;
                @(negedge clk);
                chk("qual_y0", y0, 71);
                chk("qual_ynext0", yn0, 72);
                chk("qual_vsync1", vs1, 1);
            end
        end
        chk("sof0_per_frame", sof_seen, 1);
        chk("eof0_per_frame", eof_seen, 1);

        // Advance to line 300 then reset on a coincident step.
        for (int k = 1; k <= 300; k++) begin
            do_step();
            s++;
            check_all();
        end
        chk("pre_rst_y0", y0, 271);
        @(negedge clk);
        reset = 1'b1;
        pixel_tick = 1'b1;
        eol = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pixel_tick = 1'b0;
        eol = 1'b0;
        chk("mid_rst_vsync0", vs0, 1);
        chk("mid_rst_vvideo0", vv0, 0);
        chk("mid_rst_y0", y0, 0);
        chk("mid_rst_sof0", sof0, 0);
        chk("mid_rst_eof0", eof0, 0);
        chk("mid_rst_frame0", fc0, 0);
        chk("mid_rst_pf0", pf0, 0);
        chk("mid_rst_ynext0", yn0, 0);

        // Restart from line 0 through the next sof.
        s = 0;
        for (int k = 1; k <= 35; k++) begin
            do_step();
            s++;
            check_all();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
